hd_block_loader: RTL

- Parametrised block-copy engine between the HD store and a program memory (BIOS/instruction RAM image) in the CPU/OS lab system.
- The CPU, or the OS context switch, issues one command: copy LENGTH words from a source base to a destination base, in either direction.
- The engine sequences synchronous-read/synchronous-write RAMs with a configurable read latency.
- It replaces hand-coded word-by-word copy loops in software.

---
 rtl/hd_block_loader_if.sv | 47 ++++
 rtl/hd_block_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hd_block_loader_if.sv
// Command and memory-bus bundle for hd_block_loader.
// master: the copy engine (takes commands, drives both memories' address/write side).
// slave : the surroundings (CPU/OS command source plus the HD and program RAMs).
interface hd_block_loader_if #(
   parameter int DATA_W    = 32,
   parameter int HD_ADDR_W = 12,
   parameter int PM_ADDR_W = 10,
   parameter int LEN_W     = 11
);
   localparam int BASE_W = (HD_ADDR_W > PM_ADDR_W) ? HD_ADDR_W : PM_ADDR_W;

   // command side
   logic                 start;
   logic                 dir;
   logic [BASE_W-1:0]    src_base;
   logic [BASE_W-1:0]    dst_base;
   logic [LEN_W-1:0]     length;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic                 aborted;
   logic [LEN_W-1:0]     count;

   // HD store
   logic [HD_ADDR_W-1:0] hd_addr;
   logic [DATA_W-1:0]    hd_wdata;
   logic                 hd_we;
   logic [DATA_W-1:0]    hd_rdata;

   // program memory
   logic [PM_ADDR_W-1:0] pm_addr;
   logic [DATA_W-1:0]    pm_wdata;
   logic                 pm_we;
   logic [DATA_W-1:0]    pm_rdata;

   modport master (
      input  start, dir, src_base, dst_base, length, abort, hd_rdata, pm_rdata,
      output busy, done, aborted, count,
      output hd_addr, hd_wdata, hd_we, pm_addr, pm_wdata, pm_we
   );

   modport slave (
      output start, dir, src_base, dst_base, length, abort, hd_rdata, pm_rdata,
      input  busy, done, aborted, count,
      input  hd_addr, hd_wdata, hd_we, pm_addr, pm_wdata, pm_we
   );
endinterface

// File: rtl/hd_block_loader.sv
// Block-copy engine between the HD store and program memory.
// One command copies `length` words from src_base to dst_base in either
// direction; each word costs READ + RD_LAT x WAIT + WRITE cycles.
// Optional feature: define HD_BLOCK_LOADER_CHECKSUM_EN to add a running
// modulo-2^DATA_W sum of all written words on the `checksum` port.
module hd_block_loader #(
   parameter int DATA_W    = 32,
   parameter int HD_ADDR_W = 12,
   parameter int PM_ADDR_W = 10,
   parameter int LEN_W     = 11,
   parameter int RD_LAT    = 1
) (
   input  logic                 clock,
   input  logic                 resetCPU,
   hd_block_loader_if.master    bus
`ifdef HD_BLOCK_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]    checksum
`endif
);

   localparam int BASE_W = (HD_ADDR_W > PM_ADDR_W) ? HD_ADDR_W : PM_ADDR_W;
   localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

   state_t               state_q, state_n;
   logic                 dir_q, dir_n;
   logic [BASE_W-1:0]    src_q, src_n;
   logic [BASE_W-1:0]    dst_q, dst_n;
   logic [LEN_W-1:0]     len_q, len_n;
   logic [LAT_W-1:0]     lat_q, lat_n;

   logic [LEN_W-1:0]     count_n;
   logic [HD_ADDR_W-1:0] hd_addr_n;
   logic [PM_ADDR_W-1:0] pm_addr_n;
   logic [DATA_W-1:0]    hd_wdata_n, pm_wdata_n;
   logic                 hd_we_n, pm_we_n, busy_n, done_n, aborted_n;

   // Next state and next value of every registered output
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
      state_n    = state_q;
      dir_n      = dir_q;
      src_n      = src_q;
      dst_n      = dst_q;
      len_n      = len_q;
      lat_n      = lat_q;
      count_n    = bus.count;
      hd_addr_n  = bus.hd_addr;
      pm_addr_n  = bus.pm_addr;
      hd_wdata_n = bus.hd_wdata;
      pm_wdata_n = bus.pm_wdata;
      aborted_n  = 1'b0;

      if (state_q != IDLE && bus.abort) begin
         // A write presented this cycle lands, so it is counted; nothing follows it.
         state_n   = IDLE;
         aborted_n = 1'b1;
         if (state_q == WRITE) count_n = bus.count + LEN_W'(1);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  dir_n   = bus.dir;
                  src_n   = bus.src_base;
                  dst_n   = bus.dst_base;
                  len_n   = bus.length;
                  count_n = '0;
                  state_n = (bus.length == '0) ? FIN : READ;
               end
            end
            READ: begin
               lat_n   = '0;
               state_n = WAIT;
            end
            WAIT: begin
               if (lat_q == LAT_W'(RD_LAT - 1)) begin
                  // Source data is valid now; it becomes the destination's write data.
                  if (dir_q) hd_wdata_n = bus.pm_rdata;
                  else       pm_wdata_n = bus.hd_rdata;
                  state_n = WRITE;
               end else begin
                  lat_n = lat_q + LAT_W'(1);
               end
            end
            WRITE: begin
               count_n = bus.count + LEN_W'(1);
               state_n = (count_n == len_q) ? FIN : READ;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end

      // Addresses are offset by the words already written and wrap at the memory size.
      if (state_n == READ) begin
         if (dir_n) pm_addr_n = src_n[PM_ADDR_W-1:0] + PM_ADDR_W'(count_n);
         else       hd_addr_n = src_n[HD_ADDR_W-1:0] + HD_ADDR_W'(count_n);
      end
      if (state_n == WRITE) begin
         if (dir_n) hd_addr_n = dst_n[HD_ADDR_W-1:0] + HD_ADDR_W'(count_n);
         else       pm_addr_n = dst_n[PM_ADDR_W-1:0] + PM_ADDR_W'(count_n);
      end

      hd_we_n = (state_n == WRITE) &&  dir_n;
      pm_we_n = (state_n == WRITE) && !dir_n;
      busy_n  = (state_n != IDLE);
      done_n  = (state_n == FIN);
   end

   // State, latched command and registered outputs
   always_ff @(posedge clock or negedge resetCPU) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!resetCPU) begin
         state_q      <= IDLE;
         dir_q        <= 1'b0;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         lat_q        <= '0;
         bus.count    <= '0;
         bus.hd_addr  <= '0;
         bus.pm_addr  <= '0;
         bus.hd_wdata <= '0;
         bus.pm_wdata <= '0;
         bus.hd_we    <= 1'b0;
         bus.pm_we    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.aborted  <= 1'b0;
      end else begin
         state_q      <= state_n;
         dir_q        <= dir_n;
         src_q        <= src_n;
         dst_q        <= dst_n;
         len_q        <= len_n;
         lat_q        <= lat_n;
         bus.count    <= count_n;
         bus.hd_addr  <= hd_addr_n;
         bus.pm_addr  <= pm_addr_n;
         bus.hd_wdata <= hd_wdata_n;
         bus.pm_wdata <= pm_wdata_n;
         bus.hd_we    <= hd_we_n;
         bus.pm_we    <= pm_we_n;
         bus.busy     <= busy_n;
         bus.done     <= done_n;
         bus.aborted  <= aborted_n;
      end
   end

`ifdef HD_BLOCK_LOADER_CHECKSUM_EN
   // Running sum of the words written by the current command
   always_ff @(posedge clock or negedge resetCPU) begin
      if (!resetCPU)                         checksum <= '0;
      else if (state_q == IDLE && bus.start) checksum <= '0;
      else if (state_q == WRITE)             checksum <= checksum + (dir_q ? bus.hd_wdata : bus.pm_wdata);
   end
`endif

endmodule
